// File: rtl/imm_decode_stage_if.sv
// Handshake bundle between fetch and the immediate-decode stage.
// Upstream carries raw instructions, downstream carries decoded fields.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_out;
  logic            illegal;

  modport master (
    output in_valid,
    input  in_ready,
    output instr,
    output pc,
    input  out_valid,
    output out_ready,
    input  imm,
    input  fmt,
    input  target,
    input  pc_out,
    input  illegal
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  instr,
    input  pc,
    output out_valid,
    input  out_ready,
    output imm,
    output fmt,
    output target,
    output pc_out,
    output illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: extracts and extends the immediate, computes
// pc+imm, and buffers results in a two-entry main/skid register pair.
module imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  imm_decode_stage_if.slave bus
);

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;
  localparam logic [2:0] F_CSR  = 3'd6;
  localparam logic [2:0] F_SH   = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            ill;
  } ent_t;

  logic [6:0] op;
  logic [2:0] f3;
  logic       is_opi;
  logic       is_w;
  logic       c_r;
  logic       c_i;
  logic       c_s;
  logic       c_b;
  logic       c_u;
  logic       c_j;
  logic       c_z;
  logic       c_sh;
  logic [5:0] shamt;

  logic signed [11:0] i12;
  logic signed [11:0] s12;
  logic signed [12:0] b13;
  logic signed [31:0] u32;
  logic signed [20:0] j21;

  ent_t d;
  ent_t main_q;
  ent_t main_n;
  ent_t skid_q;
  ent_t skid_n;
  logic mv_q;
  logic mv_n;
  logic sf_q;
  logic sf_n;
  logic rdy_q;
  logic acc;
  logic pop;

  assign op = bus.instr[6:0];
  assign f3 = bus.instr[14:12];

  assign is_opi = op == 7'b0010011;
  assign is_w   = RV64_OPS && (op == 7'b0011011);
  assign c_sh   = (is_opi || is_w) && (f3[1:0] == 2'b01);
  assign c_r    = op == 7'b0110011;
  assign c_i    = ((is_opi || is_w) && !c_sh)
               || (op == 7'b0000011)
               || (op == 7'b1100111)
               || ((op == 7'b1110011) && !f3[2]);
  assign c_s    = op == 7'b0100011;
  assign c_b    = op == 7'b1100011;
  assign c_u    = (op == 7'b0110111) || (op == 7'b0010111);
  assign c_j    = op == 7'b1101111;
  assign c_z    = (op == 7'b1110011) && f3[2];

  // Word shifts keep a 5-bit shamt even on RV64.
  assign shamt = (XLEN == 64 && is_opi)
               ? bus.instr[25:20]
               : {1'b0, bus.instr[24:20]};

  assign i12 = bus.instr[31:20];
  assign s12 = {bus.instr[31:25], bus.instr[11:7]};
  assign b13 = {bus.instr[31], bus.instr[7],
                bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign u32 = {bus.instr[31:12], 12'b0};
  assign j21 = {bus.instr[31], bus.instr[19:12],
                bus.instr[20], bus.instr[30:21], 1'b0};

  always_comb begin
    d     = '0;
    d.pc  = bus.pc;
    unique case (1'b1)
      c_r:  d.fmt = F_NONE;
      c_i: begin
        d.fmt = F_I;
        d.imm = XLEN'(i12);
      end
      c_s: begin
        d.fmt = F_S;
        d.imm = XLEN'(s12);
      end
      c_b: begin
        d.fmt = F_B;
        d.imm = XLEN'(b13);
      end
      c_u: begin
        d.fmt = F_U;
        d.imm = XLEN'(u32);
      end
      c_j: begin
        d.fmt = F_J;
        d.imm = XLEN'(j21);
      end
      c_z: begin
        d.fmt = F_CSR;
        d.imm = XLEN'(bus.instr[19:15]);
      end
      c_sh: begin
        d.fmt = F_SH;
        d.imm = XLEN'(shamt);
      end
      default: d.ill = 1'b1;
    endcase
    d.target = bus.pc + d.imm;
  end

  assign acc = bus.in_valid && rdy_q;
  assign pop = mv_q && bus.out_ready;

  always_comb begin
    main_n = main_q;
    skid_n = skid_q;
    mv_n   = mv_q;
    sf_n   = sf_q;
    if (flush) begin
      mv_n = 1'b0;
      sf_n = 1'b0;
    end else if (mv_q && !pop) begin
      if (acc) begin
        skid_n = d;
        sf_n   = 1'b1;
      end
    end else if (mv_q && sf_q) begin
      main_n = skid_q;
      sf_n   = 1'b0;
    end else if (acc) begin
      main_n = d;
      mv_n   = 1'b1;
    end else begin
      mv_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      mv_q   <= 1'b0;
      sf_q   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      main_q <= main_n;
      skid_q <= skid_n;
      mv_q   <= mv_n;
      sf_q   <= sf_n;
      rdy_q  <= !sf_n;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = mv_q;
  assign bus.imm       = main_q.imm;
  assign bus.fmt       = main_q.fmt;
  assign bus.target    = main_q.target;
  assign bus.pc_out    = main_q.pc;
  assign bus.illegal   = main_q.ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode table on RV32 and RV64
// instances plus backpressure, flush and async-reset sequences.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) b32 ();
  imm_decode_stage_if #(.XLEN(64)) b64 ();

  imm_decode_stage #(.XLEN(32), .RV64_OPS(1'b0)) u32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b32.slave)
  );

  imm_decode_stage #(.XLEN(64), .RV64_OPS(1'b1)) u64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b64.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        ill;
  } v32_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ill;
  } v64_t;

  v32_t tv[13];
  v64_t tw[4];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send32(logic [31:0] i, logic [31:0] p);
    @(negedge clk);
    b32.in_valid = 1'b1;
    b32.instr    = i;
    b32.pc       = p;
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic send64(logic [31:0] i, logic [63:0] p);
    @(negedge clk);
    b64.in_valid = 1'b1;
    b64.instr    = i;
    b64.pc       = p;
    @(posedge clk);
    #1;
    b64.in_valid = 1'b0;
  endtask

  initial begin
    tv[0]  = '{32'hFFF00093, 32'h0,    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    tv[1]  = '{32'hFE112E23, 32'h0,    3'd2, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0};
    tv[2]  = '{32'hFE000CE3, 32'h100,  3'd3, 32'hFFFFFFF8, 32'h000000F8, 1'b0};
    tv[3]  = '{32'h123450B7, 32'h10,   3'd4, 32'h12345000, 32'h12345010, 1'b0};
    tv[4]  = '{32'h001000EF, 32'h200,  3'd5, 32'h00000800, 32'h00000A00, 1'b0};
    tv[5]  = '{32'h002081B3, 32'h40,   3'd0, 32'h0,        32'h40,       1'b0};
    tv[6]  = '{32'h01F09093, 32'h0,    3'd7, 32'h1F,       32'h1F,       1'b0};
    tv[7]  = '{32'h4030D093, 32'h0,    3'd7, 32'h3,        32'h3,        1'b0};
    tv[8]  = '{32'h3002D073, 32'h0,    3'd6, 32'h5,        32'h5,        1'b0};
    tv[9]  = '{32'h300110F3, 32'h0,    3'd1, 32'h300,      32'h300,      1'b0};
    tv[10] = '{32'h00000010, 32'h50,   3'd0, 32'h0,        32'h50,       1'b1};
    tv[11] = '{32'h0010009B, 32'h60,   3'd0, 32'h0,        32'h60,       1'b1};
    tv[12] = '{32'hFFFFF097, 32'h2000, 3'd4, 32'hFFFFF000, 32'h1000,     1'b0};

    tw[0] = '{32'h001000EF, 64'hFFFFFFFFFFFFF800, 3'd5,
              64'h800, 64'h0, 1'b0};
    tw[1] = '{32'hFFF0809B, 64'h0, 3'd1,
              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tw[2] = '{32'h03F09093, 64'h0, 3'd7, 64'h3F, 64'h3F, 1'b0};
    tw[3] = '{32'h800000B7, 64'h0, 3'd4,
              64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};

    b32.in_valid = 1'b0;
    b32.instr = '0;
    b32.pc = '0;
    b32.out_ready = 1'b1;
    b64.in_valid = 1'b0;
    b64.instr = '0;
    b64.pc = '0;
    b64.out_ready = 1'b1;

    #12;
    chk("rst_in_ready", 64'(b32.in_ready), 64'h0);
    chk("rst_out_valid", 64'(b32.out_valid), 64'h0);
    chk("rst_imm", 64'(b32.imm), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(b32.in_ready), 64'h1);

    for (int i = 0; i < 13; i++) begin
      send32(tv[i].instr, tv[i].pc);
      chk($sformatf("v%0d_valid", i), 64'(b32.out_valid), 64'h1);
      chk($sformatf("v%0d_fmt", i), 64'(b32.fmt), 64'(tv[i].fmt));
      chk($sformatf("v%0d_imm", i), 64'(b32.imm), 64'(tv[i].imm));
      chk($sformatf("v%0d_tgt", i), 64'(b32.target), 64'(tv[i].tgt));
      chk($sformatf("v%0d_ill", i), 64'(b32.illegal), 64'(tv[i].ill));
      chk($sformatf("v%0d_pc", i), 64'(b32.pc_out), 64'(tv[i].pc));
    end

    for (int i = 0; i < 4; i++) begin
      send64(tw[i].instr, tw[i].pc);
      chk($sformatf("w%0d_valid", i), 64'(b64.out_valid), 64'h1);
      chk($sformatf("w%0d_fmt", i), 64'(b64.fmt), 64'(tw[i].fmt));
      chk($sformatf("w%0d_imm", i), b64.imm, tw[i].imm);
      chk($sformatf("w%0d_tgt", i), b64.target, tw[i].tgt);
      chk($sformatf("w%0d_ill", i), 64'(b64.illegal), 64'(tw[i].ill));
    end

    // backpressure: A then B held, then drained in order
    @(negedge clk);
    @(negedge clk);
    b32.out_ready = 1'b0;
    send32(32'h00100093, 32'h0);
    chk("bp_a_imm", 64'(b32.imm), 64'h1);
    chk("bp_a_rdy", 64'(b32.in_ready), 64'h1);
    send32(32'h00200093, 32'h4);
    chk("bp_b_rdy", 64'(b32.in_ready), 64'h0);
    chk("bp_a_hold", 64'(b32.imm), 64'h1);
    @(posedge clk);
    #1;
    chk("bp_a_hold2", 64'(b32.imm), 64'h1);
    chk("bp_a_pc", 64'(b32.pc_out), 64'h0);
    @(negedge clk);
    b32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_b_valid", 64'(b32.out_valid), 64'h1);
    chk("bp_b_imm", 64'(b32.imm), 64'h2);
    chk("bp_b_pc", 64'(b32.pc_out), 64'h4);
    chk("bp_rdy_back", 64'(b32.in_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("bp_empty", 64'(b32.out_valid), 64'h0);

    // flush with a full buffer and a new offer
    b32.out_ready = 1'b0;
    send32(32'h00100093, 32'h0);
    send32(32'h00200093, 32'h4);
    chk("fl_full", 64'(b32.in_ready), 64'h0);
    @(negedge clk);
    flush = 1'b1;
    b32.in_valid = 1'b1;
    b32.instr = 32'h00300093;
    @(posedge clk);
    #1;
    flush = 1'b0;
    b32.in_valid = 1'b0;
    chk("fl_valid", 64'(b32.out_valid), 64'h0);
    chk("fl_rdy", 64'(b32.in_ready), 64'h1);
    b32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("fl_drop%0d", i), 64'(b32.out_valid), 64'h0);
    end

    // async reset while stalled
    b32.out_ready = 1'b0;
    send32(32'hFFF00093, 32'h80);
    chk("ar_pre_valid", 64'(b32.out_valid), 64'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(b32.out_valid), 64'h0);
    chk("ar_imm", 64'(b32.imm), 64'h0);
    chk("ar_fmt", 64'(b32.fmt), 64'h0);
    chk("ar_tgt", 64'(b32.target), 64'h0);
    chk("ar_pc", 64'(b32.pc_out), 64'h0);
    chk("ar_rdy", 64'(b32.in_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    b32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_rdy_back", 64'(b32.in_ready), 64'h1);
    chk("ar_still_empty", 64'(b32.out_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter RV64_OPS, default 0, meaning decode OP-IMM-32 (0011011) when 1; legal only with XLEN=64.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline kill.
REQ-006 SHALL have port in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-007 SHALL have port instr  input  32  raw instruction.
REQ-008 SHALL have port pc  input  XLEN  instruction address.
REQ-009 SHALL have port out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-010 SHALL have port imm  output  XLEN  decoded, extended immediate.
REQ-011 SHALL have port fmt  output  3  0=none/R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=CSR-zimm, 7=shamt.
REQ-012 SHALL have port target  output  XLEN  pc+imm, modulo 2^XLEN.
REQ-013 SHALL have port pc_out  output  XLEN  pc of the presented entry.
REQ-014 SHALL have port illegal  output  1  unsupported opcode, or instr[1:0]!=2'b11.

Function
REQ-015 SHALL accept an entry when in_valid && in_ready, and present it when out_valid && out_ready; a transfer occurs only on the clock edge where both signals of a pair are high.
REQ-016 SHALL be a two-entry buffer (main + skid); in_ready SHALL be registered and equal !skid_full.
REQ-017 Latency SHALL be 1 cycle: an entry accepted at edge N is on the outputs after edge N with out_valid=1, provided the buffer was empty.
REQ-018 Under backpressure (out_valid && !out_ready), the entry accepted that cycle SHALL go to skid, and in_ready SHALL be 0 from the next cycle.
REQ-019 Outputs SHALL be held stable while out_valid && !out_ready.
REQ-020 Ordering SHALL be FIFO; on drain, skid moves to main in the same edge, and in_ready returns to 1 after that edge.
REQ-021 Decode SHALL be computed before registering, and the registered fields SHALL be imm, fmt, target, pc_out and illegal.
REQ-022 Decode by opcode:
  - 0010011, 0000011, 1100111 -> I: sign-extended instr[31:20].
  - 0100011 -> S: sign-extended {instr[31:25], instr[11:7]}.
  - 1100011 -> B: sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 0110111, 0010111 -> U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 1101111 -> J: sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 0110011 -> fmt 0, imm 0.
REQ-023 For OP-IMM with funct3 001/101, decode SHALL be fmt 7 with a zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-024 For 1110011 with funct3[2]=1, decode SHALL be fmt 6, imm = zero-extended instr[19:15]; other SYSTEM funct3 values SHALL decode as I.
REQ-025 0011011 SHALL decode as I (shamt rule: instr[24:20]) only when RV64_OPS=1; otherwise it SHALL be illegal.
REQ-026 An illegal entry SHALL still pass through the buffer with illegal=1, imm=0 and fmt=0.
REQ-027 target SHALL be computed for every entry; it is meaningful only for B, J and AUIPC, and carries out of XLEN SHALL be discarded.
REQ-028 flush=1 at edge N SHALL clear both buffer entries and drop any input offered at N; after N, out_valid=0 and in_ready=1.
REQ-029 flush SHALL take priority over simultaneous accept and present.

Reset
REQ-030 rst_n=0 SHALL immediately clear out_valid, skid_full, imm, fmt, target, pc_out and illegal to 0, and set in_ready=0.
REQ-031 in_ready SHALL become 1 on the first rising edge with rst_n=1.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered entries, with no partial output.

Verification
REQ-033 XLEN=32: instr=0xFFF00093 -> after 1 cycle, out_valid=1, fmt=1, imm=0xFFFFFFFF.
REQ-034 instr=0xFE112E23 (sw x1,-4(x2)) -> fmt=2, imm=0xFFFFFFFC. instr=0xFE000CE3, pc=0x100 -> fmt=3, imm=0xFFFFFFF8, target=0x000000F8.
REQ-035 XLEN=64: instr=0x001000EF, pc=0xFFFFFFFFFFFFF800 -> fmt=5, imm=0x800, target=0 (wrap).
REQ-036 out_ready=0, send A then B -> in_ready=0 after B; raise out_ready -> A then B, each held stable, then in_ready=1.
REQ-037 Buffer full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered input is never output.
REQ-038 instr=0x00000013 with instr[1:0] forced to 00, and opcode 0011011 with RV64_OPS=0 -> illegal=1, imm=0. rst_n low mid-stall -> outputs 0 asynchronously.
